// File: rtl/pw_pattern_match.sv
// pw_pattern_match: compares the most recent received bytes of a packet
// against a programmable, per-bit maskable pattern and emits a one-cycle
// match pulse for pw_trigger. Arming, one-shot/continuous operation and
// suppression of matches while a capture is running are handled here.
//
// Byte stream handshake: I_fe_data is qualified only by I_fe_data_valid;
// there is no ready. Every valid byte seen while I_fe_rxactive is high is
// accepted in that cycle. Valid bytes with rxactive low are dropped.
module pw_pattern_match #(
    parameter int pPATTERN_BYTES = 8,
    parameter int pBYTES_WIDTH   = 4,
    parameter int pCOUNT_WIDTH   = 16
) (
    input  logic                        fe_clk,
    input  logic                        reset_n,
    input  logic [7:0]                  I_fe_data,
    input  logic                        I_fe_data_valid,
    input  logic                        I_fe_rxactive,
    input  logic [8*pPATTERN_BYTES-1:0] I_pattern,
    input  logic [8*pPATTERN_BYTES-1:0] I_mask,
    input  logic [pBYTES_WIDTH-1:0]     I_pattern_bytes,
    input  logic                        I_arm,
    input  logic                        I_disarm,
    input  logic                        I_continuous,
    input  logic                        I_capturing,
    output logic                        O_match,
    output logic                        O_armed,
    output logic [pCOUNT_WIDTH-1:0]     O_match_count,
    output logic                        O_state
);

    localparam int N  = pPATTERN_BYTES;
    localparam int HW = 8 * N;
    localparam int FW = $clog2(N + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [HW-1:0]   hist;
    logic [HW-1:0]   cand;
    logic [FW-1:0]   fill;
    logic [FW-1:0]   leff;
    logic            accept;
    logic            fill_ok;
    logic            bytes_ok;
    logic            hit;
    logic            qualified;
    logic            match_d;
    logic            clr_cnt;

    assign accept = I_fe_data_valid & I_fe_rxactive;
    assign cand   = {hist[HW-9:0], I_fe_data};

    // Clamp the programmed length to the pattern capacity.
    always_comb begin
        if (I_pattern_bytes > pBYTES_WIDTH'(N))
            leff = FW'(N);
        else
            leff = FW'(I_pattern_bytes);
    end

    // Enough bytes of this packet, including the current one, to cover Leff.
    assign fill_ok = ((FW+1)'(fill) + (FW+1)'(1)) >= (FW+1)'(leff);

    // Every compared byte must agree on all of its enabled bits.
    always_comb begin
        bytes_ok = 1'b1;
        for (int k = 0; k < N; k++) begin
            if ((k < int'(leff)) &&
                (((cand[8*k +: 8] ^ I_pattern[8*k +: 8]) & I_mask[8*k +: 8]) != 8'h00))
                bytes_ok = 1'b0;
        end
    end

    assign hit       = accept & fill_ok & (leff != '0) & bytes_ok;
    assign qualified = hit & ~I_capturing & ~I_disarm & (state == S_ARMED);

    // Byte history: shift in each accepted byte, newest in the low byte.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            hist <= '0;
        else if (accept)
            hist <= cand;
    end

    // Packet fill level: saturates at N, cleared whenever rxactive is low.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            fill <= '0;
        else if (!I_fe_rxactive)
            fill <= '0;
        else if (accept && (fill != FW'(N)))
            fill <= fill + FW'(1);
    end

    // State register.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; disarm wins over arm and over a hit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!I_disarm && I_arm)
                    state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (I_disarm)
                    state_nxt = S_IDLE;
                else if (qualified && !I_continuous)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: match strobe, counter clear, armed flag, debug state.
    always_comb begin
        match_d = qualified;
        clr_cnt = I_arm & ~I_disarm;
        O_armed = (state == S_ARMED);
        O_state = state;
    end

    // Match pulse register: one cycle per qualified hit.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            O_match <= 1'b0;
        else
            O_match <= match_d;
    end

    // Match counter: an arm restarts it (a hit in the same cycle counts as
    // the first match), otherwise it counts pulses and saturates.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n)
            O_match_count <= '0;
        else if (clr_cnt)
            O_match_count <= {{(pCOUNT_WIDTH-1){1'b0}}, match_d};
        else if (match_d && (O_match_count != '1))
            O_match_count <= O_match_count + pCOUNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_pw_pattern_match.sv
// tb_pw_pattern_match: directed stimulus for pw_pattern_match with a
// queue-based reference model and per-cycle output comparison.
module tb_pw_pattern_match;

  localparam int N  = 8;
  localparam int BW = 4;
  localparam int CW = 16;

  // ---------------- clock / reset ----------------
  logic fe_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 fe_clk = ~fe_clk;

  logic [7:0]     I_fe_data = '0;
  logic           I_fe_data_valid = 1'b0;
  logic           I_fe_rxactive = 1'b0;
  logic [8*N-1:0] I_pattern = '0;
  logic [8*N-1:0] I_mask = '0;
  logic [BW-1:0]  I_pattern_bytes = '0;
  logic           I_arm = 1'b0;
  logic           I_disarm = 1'b0;
  logic           I_continuous = 1'b0;
  logic           I_capturing = 1'b0;
  logic           O_match;
  logic           O_armed;
  logic [CW-1:0]  O_match_count;
  logic           O_state;

  pw_pattern_match #(
    .pPATTERN_BYTES(N),
    .pBYTES_WIDTH(BW),
    .pCOUNT_WIDTH(CW)
  ) dut (
    .fe_clk(fe_clk),
    .reset_n(reset_n),
    .I_fe_data(I_fe_data),
    .I_fe_data_valid(I_fe_data_valid),
    .I_fe_rxactive(I_fe_rxactive),
    .I_pattern(I_pattern),
    .I_mask(I_mask),
    .I_pattern_bytes(I_pattern_bytes),
    .I_arm(I_arm),
    .I_disarm(I_disarm),
    .I_continuous(I_continuous),
    .I_capturing(I_capturing),
    .O_match(O_match),
    .O_armed(O_armed),
    .O_match_count(O_match_count),
    .O_state(O_state)
  );

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // pkt holds the bytes of the current packet, newest at index 0.
  logic [7:0]    pkt[$];
  logic          m_match = 1'b0;
  logic          m_armed = 1'b0;
  logic [CW-1:0] m_cnt = '0;

  always @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt.delete();
      m_match = 1'b0;
      m_armed = 1'b0;
      m_cnt = '0;
    end else begin
      int l;
      logic hit;
      logic fire;
      hit = 1'b0;
      l = (int'(I_pattern_bytes) > N) ? N : int'(I_pattern_bytes);
      if (I_fe_data_valid && I_fe_rxactive) begin
        pkt.push_front(I_fe_data);
        if (pkt.size() > N) void'(pkt.pop_back());
        if (l != 0 && pkt.size() >= l) begin
          hit = 1'b1;
          for (int k = 0; k < l; k++)
            if (((pkt[k] ^ I_pattern[8*k +: 8]) & I_mask[8*k +: 8]) != 8'h00) hit = 1'b0;
        end
      end
      if (!I_fe_rxactive) pkt.delete();
      fire = hit && m_armed && !I_disarm && !I_capturing;
      if (I_arm && !I_disarm) m_cnt = fire ? CW'(1) : '0;
      else if (fire && m_cnt != '1) m_cnt = m_cnt + 1'b1;
      if (I_disarm) m_armed = 1'b0;
      else if (fire && !I_continuous) m_armed = 1'b0;
      else if (I_arm) m_armed = 1'b1;
      m_match = fire;
    end
  end

  // ---------------- scoreboard compare, every cycle out of reset ----------------
  always @(negedge fe_clk) begin
    if (reset_n) begin
      check("cyc_match", 32'(O_match), 32'(m_match));
      check("cyc_armed", 32'(O_armed), 32'(m_armed));
      check("cyc_state", 32'(O_state), 32'(m_armed));
      check("cyc_count", 32'(O_match_count), 32'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge fe_clk);
  endtask

  task automatic send(input logic [7:0] d, input logic cap = 1'b0, input logic dis = 1'b0);
    I_fe_rxactive = 1'b1;
    I_fe_data_valid = 1'b1;
    I_fe_data = d;
    I_capturing = cap;
    I_disarm = dis;
    step();
    I_fe_data_valid = 1'b0;
    I_capturing = 1'b0;
    I_disarm = 1'b0;
  endtask

  task automatic end_pkt();
    I_fe_rxactive = 1'b0;
    I_fe_data_valid = 1'b0;
    step();
  endtask

  task automatic arm();
    I_arm = 1'b1;
    step();
    I_arm = 1'b0;
  endtask

  task automatic disarm();
    I_disarm = 1'b1;
    step();
    I_disarm = 1'b0;
  endtask

  task automatic cfg(input logic [8*N-1:0] p, input logic [8*N-1:0] m,
                     input logic [BW-1:0] l, input logic c);
    I_pattern = p;
    I_mask = m;
    I_pattern_bytes = l;
    I_continuous = c;
  endtask

  localparam logic [8*N-1:0] PAT_SOF = 64'h0000_0000_002D_0010;
  localparam logic [8*N-1:0] ALL1 = '1;

  // ---------------- directed sequence ----------------
  initial begin
    step();
    check("rst_match", 32'(O_match), 32'd0);
    check("rst_armed", 32'(O_armed), 32'd0);
    check("rst_count", 32'(O_match_count), 32'd0);
    #3 reset_n = 1'b1;
    step();

    // one-shot
    cfg(PAT_SOF, ALL1, 4'd3, 1'b0);
    arm();
    check("arm_armed", 32'(O_armed), 32'd1);
    send(8'h2D); send(8'h00);
    check("os_nomatch_early", 32'(O_match), 32'd0);
    send(8'h10);
    check("os_match", 32'(O_match), 32'd1);
    check("os_disarmed", 32'(O_armed), 32'd0);
    send(8'h2D); send(8'h00); send(8'h10);
    check("os_no_second", 32'(O_match), 32'd0);
    end_pkt();
    check("os_count", 32'(O_match_count), 32'd1);

    // continuous, second hit suppressed by capture
    cfg(PAT_SOF, ALL1, 4'd3, 1'b1);
    arm();
    check("arm_clears_count", 32'(O_match_count), 32'd0);
    send(8'h2D); send(8'h00); send(8'h10);
    send(8'h2D); send(8'h00); send(8'h10, 1'b1);
    check("cap_suppressed", 32'(O_match), 32'd0);
    end_pkt();
    check("cap_count", 32'(O_match_count), 32'd1);
    check("cont_still_armed", 32'(O_armed), 32'd1);
    arm();
    send(8'h2D); send(8'h00); send(8'h10);
    send(8'h2D); send(8'h00); send(8'h10);
    check("cont_match2", 32'(O_match), 32'd1);
    end_pkt();
    check("cont_count", 32'(O_match_count), 32'd2);
    disarm();

    // all-zero mask, back-to-back pulses
    cfg('0, '0, 4'd2, 1'b1);
    arm();
    send(8'hAA);
    check("zmask_fill_short", 32'(O_match), 32'd0);
    send(8'hBB); send(8'hCC);
    check("zmask_b2b", 32'(O_match), 32'd1);
    end_pkt();
    check("zmask_count", 32'(O_match_count), 32'd2);
    disarm();

    // masking and length
    cfg(64'h55A0, 64'hFFF0, 4'd2, 1'b0);
    arm();
    send(8'h55); send(8'hA7);
    check("mask_match", 32'(O_match), 32'd1);
    end_pkt();
    arm();
    send(8'h55); send(8'hB7);
    check("mask_nomatch", 32'(O_match), 32'd0);
    end_pkt();
    I_pattern_bytes = 4'd0;
    send(8'h55); send(8'hA0); send(8'h55); send(8'hA0);
    check("len0_nomatch", 32'(O_match), 32'd0);
    end_pkt();
    cfg(64'h0102_0304_0506_0708, ALL1, 4'd12, 1'b0);
    for (int i = 2; i <= 8; i++) send(8'(i));
    check("len12_short", 32'(O_match), 32'd0);
    end_pkt();
    for (int i = 1; i <= 8; i++) send(8'(i));
    check("len12_as8", 32'(O_match), 32'd1);
    end_pkt();

    // packet boundary, including a valid byte on the falling rxactive cycle
    cfg(PAT_SOF, ALL1, 4'd3, 1'b0);
    arm();
    send(8'h2D); send(8'h00);
    I_fe_rxactive = 1'b0; I_fe_data_valid = 1'b1; I_fe_data = 8'h10;
    step();
    I_fe_data_valid = 1'b0;
    send(8'h10);
    check("boundary_nomatch", 32'(O_match), 32'd0);
    check("boundary_armed", 32'(O_armed), 32'd1);
    end_pkt();
    disarm();

    // priority
    cfg(PAT_SOF, ALL1, 4'd3, 1'b1);
    arm();
    send(8'h2D); send(8'h00); send(8'h10);
    send(8'h2D); send(8'h00); send(8'h10, 1'b0, 1'b1);
    check("prio_no_match", 32'(O_match), 32'd0);
    check("prio_disarmed", 32'(O_armed), 32'd0);
    check("prio_count", 32'(O_match_count), 32'd1);
    end_pkt();
    I_arm = 1'b1; I_disarm = 1'b1;
    step();
    I_arm = 1'b0; I_disarm = 1'b0;
    check("arm_disarm_idle", 32'(O_armed), 32'd0);
    check("arm_disarm_count", 32'(O_match_count), 32'd1);

    // asynchronous reset during a match pulse
    cfg(PAT_SOF, ALL1, 4'd3, 1'b0);
    arm();
    send(8'h2D); send(8'h00); send(8'h10);
    check("pre_rst_match", 32'(O_match), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("arst_match", 32'(O_match), 32'd0);
    check("arst_armed", 32'(O_armed), 32'd0);
    check("arst_count", 32'(O_match_count), 32'd0);
    step();
    #3 reset_n = 1'b1;
    step();
    send(8'h2D); send(8'h00); send(8'h10);
    check("post_rst_unarmed", 32'(O_match), 32'd0);
    end_pkt();
    arm();
    send(8'h2D); send(8'h00); send(8'h10);
    check("rearm_match", 32'(O_match), 32'd1);
    end_pkt();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
